// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Smallest usable bit period; three-point majority sampling needs room
    // for counts h-1, h and h+1 inside one bit.
    localparam int unsigned MIN_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_PUSH
    } rx_state_e;

    // cfg_data_bits encoding
    typedef enum logic [1:0] {
        DBITS_5 = 2'b00,
        DBITS_6 = 2'b01,
        DBITS_7 = 2'b10,
        DBITS_8 = 2'b11
    } data_bits_e;

    // Index of the final data bit for a given encoding (5 bits -> 4, 8 bits -> 7).
    function automatic logic [2:0] last_bit_idx(input data_bits_e db);
        return 3'd4 + {1'b0, db};
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; a write into a full FIFO is accepted only when a
// pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_rd;
    logic          do_wr;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign count   = count_q;
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write port.
    // NOTE: the storage array has no reset; rd_data is forced to zero while
    // empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser, oversampling bit timer with three-point
// majority vote, frame FSM with parity/stop checks, and a receive FIFO.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic [1:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic                          busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e              state_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       div_q;
    logic [2:0]             bit_idx_q;
    logic [2:0]             last_idx_q;
    logic [7:0]             data_q;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   stop2_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   s0_q;
    logic                   s1_q;
    logic                   frame_err_q;
    logic                   parity_err_q;
    logic                   overrun_q;

    logic [DIV_W-1:0]       div_in;
    logic [DIV_W-1:0]       half;
    logic                   at_pre;
    logic                   at_mid;
    logic                   at_decide;
    logic                   at_end;
    logic                   maj;
    logic                   fifo_empty;
    logic                   fifo_ok;
    logic                   wr_en;

    assign rxs       = sync_q[SYNC_STAGES-1];
    assign div_in    = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;
    assign half      = div_q >> 1;
    assign at_pre    = (cnt_q == half - DIV_W'(1));
    assign at_mid    = (cnt_q == half);
    assign at_decide = (cnt_q == half + DIV_W'(1));
    assign at_end    = (cnt_q == div_q - DIV_W'(1));
    assign maj       = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);

    assign rd_valid  = !fifo_empty;
    // A full FIFO still accepts the byte when a pop retires the head this cycle.
    assign fifo_ok   = !fifo_full || (rd_en && rd_valid);
    assign wr_en     = (state_q == ST_PUSH) && !ferr_q && !perr_q && fifo_ok;

    assign busy       = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2};
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    // Metastability synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    // Capture the two early votes; the third is the live rxs at the decision count.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            if (at_pre) s0_q <= rxs;
            if (at_mid) s1_q <= rxs;
        end
    end

    // Frame FSM with bit timer, data assembly, error flags and registered pulses.
    // NOTE: every assignment here is non-blocking, so all branches read the
    // pre-edge values of the registers regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= DIV_W'(MIN_DIV);
            bit_idx_q    <= '0;
            last_idx_q   <= 3'd7;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= at_end ? '0 : cnt_q + DIV_W'(1);

            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q    <= ST_START;
                        div_q      <= div_in;
                        last_idx_q <= last_bit_idx(data_bits_e'(cfg_data_bits));
                        par_en_q   <= cfg_parity_en;
                        par_odd_q  <= cfg_parity_odd;
                        stop2_q    <= cfg_stop2;
                        bit_idx_q  <= '0;
                        data_q     <= '0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (at_decide && maj) state_q <= ST_IDLE;
                    else if (at_end)      state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_decide) data_q[bit_idx_q] <= maj;
                    if (at_end) begin
                        if (bit_idx_q == last_idx_q)
                            state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                        else
                            bit_idx_q <= bit_idx_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    if (at_decide && (maj != (^data_q ^ par_odd_q))) perr_q <= 1'b1;
                    if (at_end) state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (at_decide && !maj) ferr_q <= 1'b1;
                    if (at_decide && !stop2_q)    state_q <= ST_PUSH;
                    else if (at_end && stop2_q)   state_q <= ST_STOP2;
                end
                ST_STOP2: begin
                    if (at_decide) begin
                        if (!maj) ferr_q <= 1'b1;
                        state_q <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state_q      <= ST_IDLE;
                    frame_err_q  <= ferr_q;
                    parity_err_q <= !ferr_q && perr_q;
                    overrun_q    <= !ferr_q && !perr_q && !fifo_ok;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (data_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: the stimulus side queues expected bytes,
// a negedge monitor pops the FIFO and compares against the queue head.
module tb_uart_rx_core;

    localparam int FIFO_DEPTH = 16;
    localparam int DIV_W      = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIV_W-1:0] clk_div;
    logic [1:0]       cfg_data_bits;
    logic             cfg_parity_en;
    logic             cfg_parity_odd;
    logic             cfg_stop2;
    logic             rx;
    logic             rd_en = 1'b0;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic [4:0]       fifo_count;
    logic             fifo_full;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;
    logic             busy;

    uart_rx_core #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clk_div        (clk_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx             (rx),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .fifo_count     (fifo_count),
        .fifo_full      (fifo_full),
        .frame_err      (frame_err),
        .parity_err     (parity_err),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q [$];
    bit         drain_en    = 1'b0;
    bit         pop_at_push = 1'b0;
    bit         busy_prev   = 1'b0;
    int         bit_clks    = 16;

    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_busy_rise = 0;
    int f0, p0, o0, b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: counts error pulses, pops the FIFO when allowed, scores popped bytes.
    always @(negedge clk) begin
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (overrun)    n_ovr++;
        if (busy && !busy_prev) n_busy_rise++;
        rd_en = 1'b0;
        if (rd_valid && (drain_en || (pop_at_push && busy_prev && !busy))) begin
            if (exp_q.size() == 0) check("unexpected_byte_queue_depth", exp_q.size(), 32'd1);
            else                   check("rd_data_pop", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            rd_en = 1'b1;
        end
        busy_prev = busy;
    end

    task automatic set_cfg(input int div, input logic [1:0] db, input bit pe, input bit po, input bit s2);
        clk_div        = DIV_W'(div);
        bit_clks       = (div < 4) ? 4 : div;
        cfg_data_bits  = db;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (bit_clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                              input bit par_bit, input bit stop_a, input bit stop_b,
                              input bit two_stop);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_a);
        if (two_stop) drive_bit(stop_b);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic snap();
        f0 = n_ferr; p0 = n_perr; o0 = n_ovr; b0 = n_busy_rise;
    endtask

    task automatic drain();
        int guard = 0;
        drain_en = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        drain_en = 1'b0;
        check("drain_left_in_queue", exp_q.size(), 32'd0);
        @(negedge clk);
        check("drain_rd_valid", rd_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_rd_valid",   rd_valid,   1'b0);
        check("rst_fifo_count", fifo_count, 5'd0);
        check("rst_fifo_full",  fifo_full,  1'b0);
        check("rst_rd_data",    rd_data,    8'h00);
        check("rst_busy",       busy,       1'b0);
        check("rst_err_pulses", {frame_err, parity_err, overrun}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // 8N1, 0xA5
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("8n1_rd_valid",   rd_valid,   1'b1);
        check("8n1_rd_data",    rd_data,    8'hA5);
        check("8n1_fifo_count", fifo_count, 5'd1);
        check("8n1_err_count",  (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        @(posedge clk); #1;
        drain();

        // 7E1, 0x35 with wrong parity bit 1 (correct even parity is 0)
        set_cfg(16, 2'b10, 1'b1, 1'b0, 1'b0);
        snap();
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("7e1_parity_err_pulses", n_perr - p0, 32'd1);
        check("7e1_frame_err_pulses",  n_ferr - f0, 32'd0);
        check("7e1_fifo_count",        fifo_count,  5'd0);
        @(posedge clk); #1;

        // 8N2, second stop bit low
        set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b1);
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("8n2_frame_err_pulses",  n_ferr - f0, 32'd1);
        check("8n2_parity_err_pulses", n_perr - p0, 32'd0);
        check("8n2_fifo_count",        fifo_count,  5'd0);
        check("8n2_busy_after",        busy,        1'b0);
        @(posedge clk); #1;

        // Glitch: rx low for 3 clk in IDLE
        set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
        snap();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("glitch_start_entered", n_busy_rise - b0, 32'd1);
        check("glitch_busy",          busy,       1'b0);
        check("glitch_fifo_count",    fifo_count, 5'd0);
        check("glitch_err_count",     (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        @(posedge clk); #1;

        // 5O1 at clk_div=2 (treated as 4): 0x1B has four ones, odd parity bit 1
        set_cfg(2, 2'b00, 1'b1, 1'b1, 1'b0);
        snap();
        exp_q.push_back(8'h1B);
        send_frame(8'h1B, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("5o1_rd_data",    rd_data,    8'h1B);
        check("5o1_fifo_count", fifo_count, 5'd1);
        check("5o1_err_count",  (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        @(posedge clk); #1;
        drain();

        // Overrun: 17 bytes 0x00..0x10 with no reads
        set_cfg(16, 2'b11, 1'b0, 1'b0, 1'b0);
        snap();
        for (int i = 0; i < 17; i++) begin
            if (i < FIFO_DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        check("ovr_fifo_full",    fifo_full,   1'b1);
        check("ovr_fifo_count",   fifo_count,  5'd16);
        check("ovr_pulses",       n_ovr - o0,  32'd1);
        check("ovr_head",         rd_data,     8'h00);
        @(posedge clk); #1;
        drain();
        check("ovr_drained_count", fifo_count, 5'd0);

        // Same again with a pop in the 17th PUSH cycle: byte accepted
        snap();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            exp_q.push_back(8'h40 + 8'(i));
            send_frame(8'h40 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        exp_q.push_back(8'h50);
        pop_at_push = 1'b1;
        send_frame(8'h50, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pop_at_push = 1'b0;
        @(negedge clk);
        check("popw_ovr_pulses", n_ovr - o0, 32'd0);
        check("popw_fifo_count", fifo_count, 5'd16);
        check("popw_fifo_full",  fifo_full,  1'b1);
        check("popw_head",       rd_data,    8'h41);
        @(posedge clk); #1;
        drain();

        // Reset mid-frame: FIFO holds 0x11, reset during DATA, then 0x3C
        exp_q.push_back(8'h11);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk);
        check("midrst_busy_in_data", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_rd_valid",   rd_valid,   1'b0);
        check("midrst_fifo_count", fifo_count, 5'd0);
        check("midrst_busy",       busy,       1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        snap();
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst_new_count", fifo_count, 5'd1);
        check("midrst_new_data",  rd_data,    8'h3C);
        check("midrst_err_count", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 32'd0);
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
